rom_memory: RTL and testbench

- Parametrised program/data ROM with a request/ready handshake and a configurable number of wait states.
- Sits between the CPU address/data bus and the memory controller, and replaces fixed combinational ROM contents.
- Contents are loaded through a programming port while the CPU is idle.
- Reads outside the populated depth return zero and pulse an error flag.

---
 rtl/rom_pkg.sv | 12 +
 rtl/rom_array.sv | 25 ++
 rtl/rom_memory.sv | 110 +++++++++++
 tb/tb_rom_memory.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared types and sizing helpers for the ROM with wait-state handshake.
package rom_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam int unsigned CntWidth = 4;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rom_array.sv
// Word storage: synchronous write, asynchronous read, never reset so contents survive a CPU reset.
module rom_array #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 32,
  parameter int unsigned IdxWidth  = 5
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [IdxWidth-1:0]  wr_idx_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [IdxWidth-1:0]  rd_idx_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/rom_memory.sv
// Parametrised ROM with req/ready handshake, configurable wait states and a programming port.
module rom_memory
  import rom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  error,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic                  prog_busy
);

  localparam int unsigned IdxW = idx_width(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_in_range;
  logic                  prog_in_range;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  // In IDLE the address is being latched this edge, so read through it directly.
  assign rd_addr       = (state_q == StIdle) ? addr : addr_q;
  assign rd_in_range   = {1'b0, rd_addr} < DepthExt;
  assign prog_in_range = {1'b0, prog_addr} < DepthExt;
  assign wr_en         = prog_we && !rst && (state_q == StIdle) && !req && prog_in_range;

  rom_array #(
    .DataWidth(DATA_WIDTH),
    .Depth    (DEPTH),
    .IdxWidth (IdxW)
  ) u_array (
    .clk_i    (clk),
    .wr_en_i  (wr_en),
    .wr_idx_i (prog_addr[IdxW-1:0]),
    .wr_data_i(prog_data),
    .rd_idx_i (rd_addr[IdxW-1:0]),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d = addr;
          if (WAIT_STATES == 0) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = CntWidth'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d == StDone && state_q != StDone) begin
      data_d = rd_in_range ? rd_data : '0;
    end
  end

  always_comb begin
    data      = data_q;
    ready     = (state_q == StDone);
    error     = (state_q == StDone) && !rd_in_range;
    prog_busy = prog_we && ((state_q != StIdle) || req);
  end

endmodule

// File: tb/tb_rom_memory.sv
// Self-checking bench for rom_memory: one instance with 2 wait states, one with none.
module tb_rom_memory;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          req0 = 1'b0;
  logic          prog_we = 1'b0;
  logic          prog_we0 = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;

  logic [DW-1:0] data, data0;
  logic          ready, ready0, error, error0, prog_busy, prog_busy0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  rom_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .data(data), .ready(ready),
    .error(error), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_busy(prog_busy)
  );

  rom_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr), .data(data0), .ready(ready0),
    .error(error0), .prog_we(prog_we0), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_busy(prog_busy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a < DEPTH) ? mem_m[a[4:0]] : '0;
  endfunction

  // Write to both instances while both are idle; called at a negedge.
  task automatic prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we   = 1'b1;
    prog_we0  = 1'b1;
    prog_addr = a;
    prog_data = d;
    #1;
    check("prog_busy_idle", {31'd0, prog_busy}, 32'd0);
    check("prog_busy0_idle", {31'd0, prog_busy0}, 32'd0);
    @(negedge clk);
    prog_we  = 1'b0;
    prog_we0 = 1'b0;
    if (a < DEPTH) mem_m[a[4:0]] = d;
  endtask

  // Read on the 2-wait-state instance: ready must appear exactly 3 cycles after the
  // sampling edge. addr is switched to a_wait during the wait; poke tries a write then.
  task automatic rd2(input logic [AW-1:0] a, input logic [AW-1:0] a_wait, input bit poke);
    logic [DW-1:0] exp_d;
    exp_d = model_rd(a);
    req  = 1'b1;
    addr = a;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      req      = 1'b0;
      addr     = a_wait;
      prog_we  = 1'b0;
      if (poke && i == 0) begin
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 16'hBEEF;
        #1;
        check("prog_busy_wait", {31'd0, prog_busy}, 32'd1);
      end
      check($sformatf("ready_cyc%0d_a%0h", i, a), {31'd0, ready}, {31'd0, (i == 2)});
      if (i == 2) begin
        check($sformatf("data_a%0h", a), {16'd0, data}, {16'd0, exp_d});
        check($sformatf("error_a%0h", a), {31'd0, error}, {31'd0, (a >= DEPTH)});
      end
    end
    @(negedge clk);
    check("ready_drop", {31'd0, ready}, 32'd0);
    check("error_drop", {31'd0, error}, 32'd0);
    check("data_held", {16'd0, data}, {16'd0, exp_d});
  endtask

  // Read on the zero-wait instance: ready in the cycle right after the sampling edge.
  task automatic rd0(input logic [AW-1:0] a);
    req0 = 1'b1;
    addr = a;
    @(negedge clk);
    req0 = 1'b0;
    check($sformatf("ready0_a%0h", a), {31'd0, ready0}, 32'd1);
    check($sformatf("data0_a%0h", a), {16'd0, data0}, {16'd0, model_rd(a)});
    check($sformatf("error0_a%0h", a), {31'd0, error0}, {31'd0, (a >= DEPTH)});
    @(negedge clk);
    check("ready0_drop", {31'd0, ready0}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] init_vals [5];
    init_vals = '{16'h2000, 16'hFF00, 16'h2100, 16'h00FF, 16'h1010};

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_data0", {16'd0, data0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) prog(AW'(i), init_vals[i]);
    for (int i = 5; i < int'(DEPTH); i++) prog(AW'(i), DW'($urandom));

    for (int i = 0; i < 5; i++) rd2(AW'(i), AW'(i), 1'b0);
    rd0(16'd1);

    rd2(16'h0020, 16'h0020, 1'b0);
    rd0(16'h0020);
    rd2(16'd4, 16'd4, 1'b0);

    rd2(16'd1, 16'd1, 1'b1);
    rd2(16'd0, 16'd0, 1'b0);

    rd2(16'd2, 16'd3, 1'b0);

    // Reset while waiting: the request is dropped and data clears.
    req  = 1'b1;
    addr = 16'd2;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    check("abort_data", {16'd0, data}, 32'd0);
    @(negedge clk);
    check("abort_ready_next", {31'd0, ready}, 32'd0);
    rd2(16'd3, 16'd3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       prog(AW'($urandom_range(0, 39)), DW'($urandom));
        1:       rd2(AW'($urandom_range(0, 40)), AW'($urandom), 1'b0);
        default: rd0(AW'($urandom_range(0, 40)));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
